// File: rtl/dct_transpose_bank_ctrl.sv
// dct_transpose_bank_ctrl
// Multi-bank transpose-buffer controller sitting between DCT stage 1 (column
// writer) and stage 2 (row reader). Stage-1 columns are steered to a one-hot
// entry enable inside the current write bank. A bank becomes full after N
// accepted writes. Full banks are handed to stage 2 in order, and each bank is
// released again after N acknowledged reads.
// Up to BANKS blocks can be buffered at the same time.

module dct_transpose_bank_ctrl #(
  parameter  int N     = 8,
  parameter  int BANKS = 2,
  localparam int IW    = $clog2(N),
  localparam int BW    = $clog2(BANKS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          wr_en_col,
  output logic          wr_ready,
  output logic [N-1:0]  wr_en_entry,
  output logic [BW-1:0] wr_bank,
  output logic          col_done,
  output logic          rd_valid,
  input  logic          rd_ack,
  output logic [IW-1:0] rd_idx,
  output logic [BW-1:0] rd_bank,
  output logic          row_done,
  output logic [BW:0]   full_cnt,
  output logic          wr_ovf
);

  localparam int CW = BW + 1;

  // Bank pointers advance round-robin. The wrap is explicit because BANKS
  // need not be a power of two.
  function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
    logic [BW-1:0] nb;
    if (b == BW'(BANKS - 1)) begin
      nb = {BW{1'b0}};
    end else begin
      nb = b + BW'(1);
    end
    return nb;
  endfunction

  // Architectural state
  logic [IW-1:0]    wr_cnt_q,   wr_cnt_d;
  logic [IW-1:0]    rd_cnt_q,   rd_cnt_d;
  logic [BW-1:0]    wr_bank_q,  wr_bank_d;
  logic [BW-1:0]    rd_bank_q,  rd_bank_d;
  logic [BANKS-1:0] full_q,     full_d;
  logic [CW-1:0]    full_cnt_q, full_cnt_d;
  logic             wr_ovf_q,   wr_ovf_d;

  // Datapath decode
  logic             wr_ready_s;
  logic             rd_valid_s;
  logic             accept_s;
  logic             reject_s;
  logic             rd_fire_s;
  logic [IW-1:0]    eff_cnt_s;
  logic             col_done_s;
  logic             row_done_s;
  logic [N-1:0]     wr_en_entry_s;

  // Handshake decode. Readiness and validity depend only on registers, so
  // there is no combinational path from rd_ack to wr_ready, and none from
  // wr_en_col to rd_valid.
  always_comb begin
    wr_ready_s = ~full_q[wr_bank_q];
    rd_valid_s = full_q[rd_bank_q];
    accept_s   = wr_en_col & wr_ready_s;
    reject_s   = wr_en_col & ~wr_ready_s;
    rd_fire_s  = rd_valid_s & rd_ack;
    if (start) begin
      eff_cnt_s = {IW{1'b0}};
    end else begin
      eff_cnt_s = wr_cnt_q;
    end
    col_done_s = accept_s & (eff_cnt_s == IW'(N - 1));
    row_done_s = rd_fire_s & (rd_cnt_q == IW'(N - 1));
  end

  // One-hot entry enable for the accepted column. It is all zero when no
  // write is accepted.
  always_comb begin
    wr_en_entry_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (accept_s && (eff_cnt_s == IW'(i))) begin
        wr_en_entry_s[i] = 1'b1;
      end else begin
        wr_en_entry_s[i] = 1'b0;
      end
    end
  end

  // Write-side next state: the entry counter, the bank pointer and the sticky
  // overflow flag.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    wr_ovf_d  = wr_ovf_q | reject_s;
    if (col_done_s) begin
      wr_cnt_d  = {IW{1'b0}};
      wr_bank_d = next_bank(wr_bank_q);
    end else if (accept_s) begin
      wr_cnt_d  = eff_cnt_s + IW'(1);
    end else if (start) begin
      // A restart with no accepted write only rewinds the entry counter.
      wr_cnt_d  = {IW{1'b0}};
    end else begin
      wr_cnt_d  = wr_cnt_q;
    end
  end

  // Read-side next state: the row counter and the bank pointer.
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    if (row_done_s) begin
      rd_cnt_d  = {IW{1'b0}};
      rd_bank_d = next_bank(rd_bank_q);
    end else if (rd_fire_s) begin
      rd_cnt_d  = rd_cnt_q + IW'(1);
    end else begin
      rd_cnt_d  = rd_cnt_q;
    end
  end

  // Full flags and occupancy count. A block completing on the write side and
  // a block freeing on the read side are always in different banks, so both
  // flag updates apply. Their effect on the count cancels out.
  always_comb begin
    full_d = full_q;
    for (int b = 0; b < BANKS; b++) begin
      if (col_done_s && (wr_bank_q == BW'(b))) begin
        full_d[b] = 1'b1;
      end else if (row_done_s && (rd_bank_q == BW'(b))) begin
        full_d[b] = 1'b0;
      end else begin
        full_d[b] = full_q[b];
      end
    end
    case ({col_done_s, row_done_s})
      2'b10:   full_cnt_d = full_cnt_q + CW'(1);
      2'b01:   full_cnt_d = full_cnt_q - CW'(1);
      default: full_cnt_d = full_cnt_q;
    endcase
  end

  // State register. Synchronous reset discards all buffered and partial
  // blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q   <= {IW{1'b0}};
      rd_cnt_q   <= {IW{1'b0}};
      wr_bank_q  <= {BW{1'b0}};
      rd_bank_q  <= {BW{1'b0}};
      full_q     <= {BANKS{1'b0}};
      full_cnt_q <= {CW{1'b0}};
      wr_ovf_q   <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      full_cnt_q <= full_cnt_d;
      wr_ovf_q   <= wr_ovf_d;
    end
  end

  // Output mapping
  assign wr_ready    = wr_ready_s;
  assign wr_en_entry = wr_en_entry_s;
  assign wr_bank     = wr_bank_q;
  assign col_done    = col_done_s;
  assign rd_valid    = rd_valid_s;
  assign rd_idx      = rd_cnt_q;
  assign rd_bank     = rd_bank_q;
  assign row_done    = row_done_s;
  assign full_cnt    = full_cnt_q;
  assign wr_ovf      = wr_ovf_q;

endmodule

// File: tb/tb_dct_transpose_bank_ctrl.sv
// Testbench for dct_transpose_bank_ctrl.
// Two instances share one stimulus stream: N=8 with BANKS=2, and N=8 with
// BANKS=3. A reference model checks both instances every cycle. The model
// describes the buffer as counts of blocks written and read, plus positions
// within the current blocks.

module tb_dct_transpose_bank_ctrl;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic wr_en_col = 1'b0;
  logic rd_ack = 1'b0;

  // Instance 0 signals (BANKS=2)
  logic         wr_ready0, col_done0, rd_valid0, row_done0, wr_ovf0;
  logic [N-1:0] wr_en_entry0;
  logic [0:0]   wr_bank0, rd_bank0;
  logic [2:0]   rd_idx0;
  logic [1:0]   full_cnt0;

  // Instance 1 signals (BANKS=3)
  logic         wr_ready1, col_done1, rd_valid1, row_done1, wr_ovf1;
  logic [N-1:0] wr_en_entry1;
  logic [1:0]   wr_bank1, rd_bank1;
  logic [2:0]   rd_idx1;
  logic [2:0]   full_cnt1;

  dct_transpose_bank_ctrl #(.N(N), .BANKS(2)) dut0 (
    .clk(clk), .rst(rst), .start(start), .wr_en_col(wr_en_col),
    .wr_ready(wr_ready0), .wr_en_entry(wr_en_entry0), .wr_bank(wr_bank0),
    .col_done(col_done0), .rd_valid(rd_valid0), .rd_ack(rd_ack),
    .rd_idx(rd_idx0), .rd_bank(rd_bank0), .row_done(row_done0),
    .full_cnt(full_cnt0), .wr_ovf(wr_ovf0)
  );

  dct_transpose_bank_ctrl #(.N(N), .BANKS(3)) dut1 (
    .clk(clk), .rst(rst), .start(start), .wr_en_col(wr_en_col),
    .wr_ready(wr_ready1), .wr_en_entry(wr_en_entry1), .wr_bank(wr_bank1),
    .col_done(col_done1), .rd_valid(rd_valid1), .rd_ack(rd_ack),
    .rd_idx(rd_idx1), .rd_bank(rd_bank1), .row_done(row_done1),
    .full_cnt(full_cnt1), .wr_ovf(wr_ovf1)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model, one slot per instance
  int nb[2] = '{2, 3};
  int blk_wr[2];
  int blk_rd[2];
  int wpos[2];
  int rpos[2];
  bit ovf[2];
  bit known[2] = '{1'b0, 1'b0};

  // Last values observed on instance 0, for directed checks
  logic [31:0] last_entry0;
  logic        last_col0, last_row0;

  // Single comparison point
  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, check both instances against the model, then
  // advance the model and the clock.
  task automatic step(input logic s, input logic w, input logic a, input logic r);
    int fc, eff;
    bit ready, acc, cdone, valid, fire, rdone;
    logic [31:0] o_ready, o_entry, o_wbank, o_cdone, o_valid, o_idx, o_rbank, o_rdone, o_fc, o_ovf;
    start = s; wr_en_col = w; rd_ack = a; rst = r;
    #1;
    last_entry0 = 32'(wr_en_entry0);
    last_col0   = col_done0;
    last_row0   = row_done0;
    for (int i = 0; i < 2; i++) begin
      fc    = blk_wr[i] - blk_rd[i];
      ready = (fc < nb[i]);
      acc   = w && ready;
      eff   = s ? 0 : wpos[i];
      cdone = acc && (eff == N - 1);
      valid = (fc > 0);
      fire  = valid && a;
      rdone = fire && (rpos[i] == N - 1);
      if (i == 0) begin
        o_ready = 32'(wr_ready0); o_entry = 32'(wr_en_entry0); o_wbank = 32'(wr_bank0);
        o_cdone = 32'(col_done0); o_valid = 32'(rd_valid0);   o_idx   = 32'(rd_idx0);
        o_rbank = 32'(rd_bank0);  o_rdone = 32'(row_done0);   o_fc    = 32'(full_cnt0);
        o_ovf   = 32'(wr_ovf0);
      end else begin
        o_ready = 32'(wr_ready1); o_entry = 32'(wr_en_entry1); o_wbank = 32'(wr_bank1);
        o_cdone = 32'(col_done1); o_valid = 32'(rd_valid1);   o_idx   = 32'(rd_idx1);
        o_rbank = 32'(rd_bank1);  o_rdone = 32'(row_done1);   o_fc    = 32'(full_cnt1);
        o_ovf   = 32'(wr_ovf1);
      end
      if (!r && known[i]) begin
        chk_eq($sformatf("b%0d.wr_ready", nb[i]),    o_ready, 32'(ready));
        chk_eq($sformatf("b%0d.wr_en_entry", nb[i]), o_entry, acc ? (32'd1 << eff) : 32'd0);
        chk_eq($sformatf("b%0d.wr_bank", nb[i]),     o_wbank, 32'(blk_wr[i] % nb[i]));
        chk_eq($sformatf("b%0d.col_done", nb[i]),    o_cdone, 32'(cdone));
        chk_eq($sformatf("b%0d.rd_valid", nb[i]),    o_valid, 32'(valid));
        chk_eq($sformatf("b%0d.rd_idx", nb[i]),      o_idx,   32'(rpos[i]));
        chk_eq($sformatf("b%0d.rd_bank", nb[i]),     o_rbank, 32'(blk_rd[i] % nb[i]));
        chk_eq($sformatf("b%0d.row_done", nb[i]),    o_rdone, 32'(rdone));
        chk_eq($sformatf("b%0d.full_cnt", nb[i]),    o_fc,    32'(fc));
        chk_eq($sformatf("b%0d.wr_ovf", nb[i]),      o_ovf,   32'(ovf[i]));
      end
      if (r) begin
        blk_wr[i] = 0; blk_rd[i] = 0; wpos[i] = 0; rpos[i] = 0; ovf[i] = 1'b0; known[i] = 1'b1;
      end else begin
        if (acc) begin
          if (cdone) begin
            wpos[i] = 0; blk_wr[i]++;
          end else begin
            wpos[i] = eff + 1;
          end
        end else if (s) begin
          wpos[i] = 0;
        end
        if (fire) begin
          if (rdone) begin
            rpos[i] = 0; blk_rd[i]++;
          end else begin
            rpos[i]++;
          end
        end
        if (w && !ready) ovf[i] = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int pw, pa;
    @(negedge clk);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk_eq("rst.wr_ready", 32'(wr_ready0), 32'd1);
    chk_eq("rst.rd_valid", 32'(rd_valid0), 32'd0);
    chk_eq("rst.full_cnt", 32'(full_cnt0), 32'd0);

    // One block of 8 columns into bank 0
    repeat (8) step(0, 1, 0, 0);
    chk_eq("blk0.col_done", 32'(last_col0), 32'd1);
    chk_eq("blk0.entry7", last_entry0, 32'h80);
    chk_eq("blk0.rd_valid", 32'(rd_valid0), 32'd1);
    chk_eq("blk0.full_cnt", 32'(full_cnt0), 32'd1);

    // Second block: both banks full, then a rejected 17th write
    repeat (8) step(0, 1, 0, 0);
    chk_eq("both.full_cnt", 32'(full_cnt0), 32'd2);
    chk_eq("both.wr_ready", 32'(wr_ready0), 32'd0);
    step(0, 1, 0, 0);
    chk_eq("ovf.entry", last_entry0, 32'd0);
    chk_eq("ovf.flag", 32'(wr_ovf0), 32'd1);
    step(0, 0, 0, 0);
    chk_eq("ovf.sticky", 32'(wr_ovf0), 32'd1);

    // Drain bank 0: bank 0 becomes writable, and reading moves to bank 1
    repeat (8) step(0, 0, 1, 0);
    chk_eq("drain.row_done", 32'(last_row0), 32'd1);
    chk_eq("drain.wr_ready", 32'(wr_ready0), 32'd1);
    chk_eq("drain.wr_bank", 32'(wr_bank0), 32'd0);
    chk_eq("drain.rd_bank", 32'(rd_bank0), 32'd1);

    // Restart in the middle of a block
    step(0, 0, 0, 1);
    repeat (3) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk_eq("start.entry", last_entry0, 32'h01);
    step(0, 1, 0, 0);
    chk_eq("start.next", last_entry0, 32'h02);
    chk_eq("start.bank", 32'(wr_bank0), 32'd0);

    // Reset with one bank full and a partial block in progress
    repeat (12) step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    chk_eq("mrst.full_cnt", 32'(full_cnt0), 32'd0);
    chk_eq("mrst.rd_valid", 32'(rd_valid0), 32'd0);
    chk_eq("mrst.wr_ready", 32'(wr_ready0), 32'd1);

    // Continuous streaming with continuous reading: no overflow may occur
    repeat (5 * N + 12) step(0, 1, 1, 0);
    chk_eq("stream.ovf3", 32'(wr_ovf1), 32'd0);
    chk_eq("stream.ovf2", 32'(wr_ovf0), 32'd0);

    // Randomized phase with varying write and read pressure
    for (int seg = 0; seg < 8; seg++) begin
      pw = 20 + 10 * seg;
      pa = 90 - 10 * seg;
      repeat (400) begin
        step($urandom_range(99) < 5, $urandom_range(99) < pw,
             $urandom_range(99) < pa, $urandom_range(999) < 3);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
